wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage and architectural register file.
- Selects the writeback value, either the ALU result or the memory load data.
- Commits that value to a 32-entry integer register file and serves two combinational read ports to the decode stage.
- Provides write-first bypass, a hard-wired x0, a forwarding tap for the EX-stage forwarding unit, and a writeback event counter.

Parameters:
- XLEN, 32, data width of registers and datapath.
- NREGS, 32, number of architectural registers; address width is log2(NREGS).
- BYPASS_EN, 1, 1 = same-cycle write-to-read bypass on the read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wb_alu_result  input  XLEN  ALU result from the MEM/WB register
- wb_mem_data  input  XLEN  load data from the MEM/WB register
- wb_rd  input  5  destination register index
- wb_reg_write  input  1  register write enable
- wb_mem_to_reg  input  1  1 = write wb_mem_data; 0 = write wb_alu_result
- rs1_addr  input  5  read port 1 index
- rs2_addr  input  5  read port 2 index
- rs1_data  output  XLEN  read port 1 data, combinational
- rs2_data  output  XLEN  read port 2 data, combinational
- wb_fwd_data  output  XLEN  selected writeback value, combinational, for the forwarding unit
- wb_fwd_valid  output  1  wb_reg_write && (wb_rd != 0), combinational
- wb_count  output  32  number of committed register writes

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Assertion of rst_n=0 immediately clears all registers x0..x31 and wb_count to 0, independent of clk.
- Release: the first commit can occur on the first rising edge after rst_n=1.
- Writeback select: wb_fwd_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result. It has zero latency and is driven regardless of wb_reg_write.
- Commit: on a rising clk edge with wb_fwd_valid=1, regs[wb_rd] <= wb_fwd_data.
- No commit: if wb_reg_write=0 or wb_rd=0, no register changes.
- x0: x0 is never written and always reads 0.
- Read ports: rsN_data = 0 if rsN_addr==0.
- Bypass: else, if BYPASS_EN and wb_fwd_valid and rsN_addr==wb_rd, rsN_data = wb_fwd_data (write-first).
- Stored value: else rsN_data = regs[rsN_addr].
- Both ports: the read rules apply independently to both ports. Both ports may address the same register.
- Without bypass: with BYPASS_EN=0, a read of the register being written this cycle returns the old value. The new value is visible the following cycle.
- wb_count: increments by 1 on each edge where a commit occurs. It wraps 0xFFFFFFFF -> 0 with no flag and is not incremented for x0 writes.
- Reset mid-operation: a commit coincident with reset assertion is discarded; reset wins.
- Undefined inputs: inputs carrying X while wb_reg_write=0 must not corrupt state.
- Out-of-range indices: if NREGS<32, indices >= NREGS are ignored on write and read as 0.

Decomposition:
- Shared package rv_pkg:
  - XLEN_DEF=32
  - REG_ADDR_W=5
  - ZERO_REG=5'd0
  - typedef reg_idx_t (5-bit)
  - typedef xword_t (XLEN-bit)
- One natural sub-module, regfile_core:
  - storage array with async-reset clear and a single write port
  - two raw combinational read ports
- wb_regfile wraps regfile_core and adds:
  - writeback mux
  - x0 masking and bypass logic
  - forwarding tap
  - counter

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Read all 32 registers via rs1/rs2 -> all 0, wb_count=0.
- ALU write then read: wb_rd=5, wb_alu_result=0xDEADBEEF, wb_mem_to_reg=0, wb_reg_write=1, one edge. Then rs1_addr=5 -> rs1_data=0xDEADBEEF, wb_count=1.
- Load select plus bypass: wb_rd=7, wb_mem_data=0x12345678, wb_alu_result=0xFFFF0000, wb_mem_to_reg=1, wb_reg_write=1, rs2_addr=7 in the same cycle. Check rs2_data=0x12345678 before the edge, wb_fwd_valid=1, and the stored value 0x12345678 after the edge.
- x0 protection: write 0xAAAAAAAA to wb_rd=0 with wb_reg_write=1. Check rs1_addr=0 -> 0 both before and after the edge, wb_fwd_valid=0, wb_count unchanged.
- Disabled write and async reset: with wb_reg_write=0 and wb_rd=3, data 0x55 -> x3 unchanged. Then, after x3=0x55 has been committed, drop rst_n mid-cycle between edges -> x3 and wb_count go to 0 before the next edge.
- Counter wrap: force or preload wb_count to 0xFFFFFFFF (via 2^32 commits or a backdoor), perform one valid commit -> wb_count=0x00000000.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared integer-datapath constants and types for the
//                writeback stage and the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int        XLEN_DEF   = 32;
    localparam int        REG_ADDR_W = 5;
    localparam logic [4:0] ZERO_REG  = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0]   xword_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_core
//  Description : Raw register storage. One synchronous write port, two
//                combinational read ports, asynchronous clear of every entry.
//                No x0 handling here; the wrapper owns architectural rules.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_we/i_waddr/i_wdata - write port
//                i_raddr1/2 -> o_rdata1/2 - raw read ports
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule : regfile_core
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage and architectural integer register file.
//                Selects ALU/load data, commits it, serves two read ports with
//                x0 masking and optional write-first bypass, exposes the
//                writeback value to the forwarding unit and counts commits.
//  Ports       : clk, rst_n                    - clock, async active-low reset
//                wb_alu_result, wb_mem_data    - writeback candidates
//                wb_rd, wb_reg_write, wb_mem_to_reg - writeback control
//                rs1_addr/rs2_addr -> rs1_data/rs2_data - read ports
//                wb_fwd_data, wb_fwd_valid     - forwarding tap
//                wb_count                      - committed write counter
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] wb_alu_result,
    input  logic [XLEN-1:0] wb_mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic            wb_mem_to_reg,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_fwd_data,
    output logic            wb_fwd_valid,
    output logic [31:0]     wb_count
);

    localparam int c_AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] w_fwd_data;
    logic            w_fwd_valid;
    logic            w_commit;
    logic [XLEN-1:0] w_raw1;
    logic [XLEN-1:0] w_raw2;
    logic [31:0]     r_wb_count;

    // Indices at or beyond NREGS have no storage: writes drop, reads give 0.
    function automatic logic in_range(input logic [4:0] idx);
        return 32'(idx) < 32'(NREGS);
    endfunction

    assign w_fwd_data  = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    assign w_fwd_valid = wb_reg_write && (wb_rd != ZERO_REG);
    // The forwarding tap reports any nonzero destination; the storage write
    // additionally needs the index to exist.
    assign w_commit    = w_fwd_valid && in_range(wb_rd);

    regfile_core #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (c_AW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_commit),
        .i_waddr  (wb_rd[c_AW-1:0]),
        .i_wdata  (w_fwd_data),
        .i_raddr1 (rs1_addr[c_AW-1:0]),
        .i_raddr2 (rs2_addr[c_AW-1:0]),
        .o_rdata1 (w_raw1),
        .o_rdata2 (w_raw2)
    );

    // Priority: x0 / nonexistent index, then same-cycle bypass, then storage.
    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] raw
    );
        if (addr == ZERO_REG || !in_range(addr)) begin
            return '0;
        end else if (BYPASS_EN != 0 && w_commit && addr == wb_rd) begin
            return w_fwd_data;
        end else begin
            return raw;
        end
    endfunction

    assign rs1_data = read_port(rs1_addr, w_raw1);
    assign rs2_data = read_port(rs2_addr, w_raw2);

    // Wraps silently at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_count <= 32'd0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign wb_fwd_data  = w_fwd_data;
    assign wb_fwd_valid = w_fwd_valid;
    assign wb_count     = r_wb_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Directed, table-driven self-checking bench for wb_regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_fwd_data;
    logic        wb_fwd_valid;
    logic [31:0] wb_count;

    int n_checks;
    int n_fail;

    wb_regfile #(
        .XLEN      (32),
        .NREGS     (32),
        .BYPASS_EN (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_fwd_data   (wb_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_count      (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [31:0] exp_fwd;
        logic        exp_valid;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic we, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_rd         = rd;
        wb_reg_write  = we;
        wb_mem_to_reg = m2r;
        wb_alu_result = alu;
        wb_mem_data   = mem;
        rs1_addr      = r1;
        rs2_addr      = r2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //        rd     we    m2r   alu            mem            rs1    rs2    exp_rs1        exp_rs2        exp_fwd        vld   cnt
        vecs[0] = '{5'd5,  1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b1, 32'd1};
        vecs[1] = '{5'd7,  1'b1, 1'b1, 32'hFFFF0000, 32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b1, 32'd2};
        vecs[2] = '{5'd0,  1'b1, 1'b0, 32'hAAAAAAAA, 32'h00000000, 5'd0,  5'd7,  32'h00000000, 32'h12345678, 32'hAAAAAAAA, 1'b0, 32'd2};
        vecs[3] = '{5'd3,  1'b0, 1'b0, 32'h00000055, 32'h00000000, 5'd3,  5'd3,  32'h00000000, 32'h00000000, 32'h00000055, 1'b0, 32'd2};
        vecs[4] = '{5'd5,  1'b1, 1'b1, 32'h00000001, 32'hCAFEF00D, 5'd5,  5'd5,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 32'd3};
        vecs[5] = '{5'd31, 1'b1, 1'b0, 32'h80000001, 32'h00000000, 5'd31, 5'd5,  32'h80000001, 32'hCAFEF00D, 32'h80000001, 1'b1, 32'd4};
        vecs[6] = '{5'd0,  1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd31, 5'd7,  32'h80000001, 32'h12345678, 32'h00000000, 1'b0, 32'd4};
        vecs[7] = '{5'd3,  1'b1, 1'b0, 32'h00000055, 32'h00000000, 5'd3,  5'd0,  32'h00000055, 32'h00000000, 32'h00000055, 1'b1, 32'd5};
        vecs[8] = '{5'd3,  1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd3,  5'd31, 32'h00000055, 32'h80000001, 32'h00000000, 1'b0, 32'd5};

        // Reset held for 3 cycles
        rst_n = 1'b0;
        drive(5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1[%0d]", i), rs1_data, 32'd0);
            check($sformatf("reset_rs2[%0d]", 31 - i), rs2_data, 32'd0);
        end
        check("reset_count", wb_count, 32'd0);

        // Table-driven writeback/read vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].we, vecs[i].m2r, vecs[i].alu, vecs[i].mem,
                  vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].exp_rs1);
            check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].exp_rs2);
            check($sformatf("v%0d_fwd", i), wb_fwd_data, vecs[i].exp_fwd);
            check($sformatf("v%0d_valid", i), {31'd0, wb_fwd_valid}, {31'd0, vecs[i].exp_valid});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), wb_count, vecs[i].exp_cnt);
        end

        // Stored values after the table (no write in flight)
        @(negedge clk);
        drive(5'd1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd7, 5'd0);
        #1;
        check("post_x7", rs1_data, 32'h12345678);
        check("post_x0_after_write", rs2_data, 32'd0);
        rs1_addr = 5'd5;
        #1;
        check("post_x5", rs1_data, 32'hCAFEF00D);

        // Async reset mid-cycle clears x3 and the counter before the next edge
        rs1_addr = 5'd3;
        #1;
        check("pre_rst_x3", rs1_data, 32'h00000055);
        rst_n = 1'b0;
        #1;
        check("async_rst_x3", rs1_data, 32'd0);
        check("async_rst_count", wb_count, 32'd0);

        // Commit coincident with reset is discarded
        drive(5'd9, 1'b1, 1'b0, 32'h00000077, 32'd0, 5'd9, 5'd0);
        @(posedge clk);
        #1;
        check("rst_commit_count", wb_count, 32'd0);
        @(negedge clk);
        drive(5'd9, 1'b0, 1'b0, 32'd0, 32'd0, 5'd9, 5'd0);
        rst_n = 1'b1;
        #1;
        check("rst_commit_x9", rs1_data, 32'd0);

        // Counter wrap via backdoor preload
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wb_count;
        #1;
        check("wrap_preload", wb_count, 32'hFFFFFFFF);
        drive(5'd4, 1'b1, 1'b0, 32'h00000004, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        check("wrap_count", wb_count, 32'd0);
        @(negedge clk);
        drive(5'd4, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4, 5'd0);
        #1;
        check("wrap_x4", rs1_data, 32'h00000004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_regfile
`default_nettype wire
